reg_bank_hs: RTL and testbench
==============================

// Module: reg_bank_hs
// PURPOSE
//  Parametrised control/status register bank with a valid/ready request channel and a
//  registered response channel. Adds byte strobes, per-register read-only and
//  write-1-to-clear modes, hardware set inputs, and an error response. Sits between a
//  local bus master and block datapaths; all registers drive reg_q continuously.
// PARAMETERS
//  DATA_W    16  register width in bits; must be a multiple of 8
//  ADDR_W    2   request address width
//  NUM_REGS  4   implemented registers, 1..2**ADDR_W; addresses >= NUM_REGS are unmapped
//  RO_MASK   0   NUM_REGS-bit mask; bit i=1: register i is read-only to the bus
//  W1C_MASK  0   NUM_REGS-bit mask; bit i=1: register i is write-1-to-clear, set by hw_set
// PORTS
//  clk        in   1                clock, rising edge
//  rstn       in   1                reset, asynchronous, active-low
//  req_valid  in   1                request present
//  req_ready  out  1                bank can accept a request
//  req_wr     in   1                1=write, 0=read
//  req_addr   in   ADDR_W           register index
//  req_wdata  in   DATA_W           write data
//  req_be     in   DATA_W/8         byte enables for writes
//  rsp_valid  out  1                response present
//  rsp_ready  in   1                master accepts response
//  rsp_rdata  out  DATA_W           read data; 0 for writes and errors
//  rsp_err    out  1                unmapped address, or write to RO register
//  hw_set     in   NUM_REGS*DATA_W  per-bit set pulses; used only for W1C registers
//  reg_q      out  NUM_REGS*DATA_W  current contents; register i at [i*DATA_W +: DATA_W]
// BEHAVIOUR
//  - Reset (rstn=0, async): all registers 0, rsp_valid 0, rsp_rdata 0, rsp_err 0.
//    A pending response is dropped. Requests arriving during reset are ignored.
//  - req_ready = !rsp_valid || rsp_ready (combinational). A request is accepted on a
//    rising edge with req_valid && req_ready. Back-to-back accepts are allowed.
//  - FSM: IDLE (rsp_valid=0) and RESP (rsp_valid=1).
//    IDLE->RESP on accept. RESP->IDLE on rsp_ready with no new accept.
//    RESP->RESP on rsp_ready with a new accept.
//    While rsp_valid=1 && !rsp_ready, rsp_rdata and rsp_err are held stable.
//  - Latency: response is valid on the cycle after accept (1 cycle).
//  - Read: rsp_rdata = register contents before the accept edge; rsp_err=0. No side
//    effects, including on W1C registers.
//  - Write to a normal register: each byte lane k with req_be[k]=1 is replaced by
//    req_wdata at the accept edge. Other lanes keep their value. rsp_err=0.
//    req_be=0 is a legal no-op write with rsp_err=0.
//  - Write to a W1C register: each bit b in an enabled lane with wdata[b]=1 is cleared.
//  - hw_set on W1C registers: any hw_set bit set to 1 sets that bit every cycle,
//    independent of the bus. When set and clear hit the same bit in the same cycle,
//    set wins (the bit ends at 1). hw_set is ignored for non-W1C registers.
//  - Write to an RO register: data is unchanged; rsp_err=1.
//  - Any access with req_addr >= NUM_REGS: no state change, rsp_rdata=0, rsp_err=1.
//  - reg_q reflects register state after each edge, with no added latency.
//  - Elaboration must fail if DATA_W%8 != 0 or NUM_REGS > 2**ADDR_W.
// TESTING
//  1. Assert rstn=0 mid-response with rsp_ready=0 -> rsp_valid drops to 0 asynchronously;
//     reg_q is all 0; after rstn=1, req_ready=1.
//  2. Write addr 1, wdata 16'hABCD, be 2'b01, starting from 0; then read addr 1 ->
//     read response rsp_rdata=16'h00CD, rsp_err=0, one cycle after accept.
//  3. Issue reads 0,1,2,3 back-to-back with rsp_ready=1 -> four consecutive
//     rsp_valid cycles and req_ready held at 1. Then drive rsp_ready=0 for 3 cycles ->
//     req_ready=0 and the response is held stable.
//  4. With W1C_MASK=4'b0100: pulse hw_set[2*16+3] -> reg 2 = 16'h0008. Write 16'h0008,
//     be 2'b11 -> reg 2 = 0. Repeat the write with the same-cycle hw_set pulse ->
//     reg 2 stays 16'h0008.
//  5. With RO_MASK=4'b1000: write addr 3 -> rsp_err=1, reg 3 unchanged.
//     With NUM_REGS=3: read addr 3 -> rsp_err=1, rsp_rdata=0.
//  6. Run a random req/rsp stream with stalls (DATA_W=32, NUM_REGS=6, ADDR_W=3)
//     against a reference model -> all responses match, in order, with no drops or
//     duplicates.

Source files
------------

// File: rtl/reg_bank_hs.sv
// reg_bank_hs: control/status register bank behind a valid/ready request channel.
// Each accepted request produces exactly one registered response, valid one cycle
// after the accept. Registers may be read-write, read-only, or write-1-to-clear
// with hardware set inputs. Every register drives reg_q continuously.
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready.
// A response transfers on a rising edge where rsp_valid && rsp_ready. While
// rsp_valid is high and rsp_ready is low, the response fields are held. A new
// request is accepted only when the response slot is empty or is draining in the
// same cycle (req_ready = !rsp_valid || rsp_ready).
module reg_bank_hs #(
  parameter int                  DATA_W   = 16,
  parameter int                  ADDR_W   = 2,
  parameter int                  NUM_REGS = 4,
  parameter logic [NUM_REGS-1:0] RO_MASK  = '0,
  parameter logic [NUM_REGS-1:0] W1C_MASK = '0
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_wr,
  input  logic [ADDR_W-1:0]          req_addr,
  input  logic [DATA_W-1:0]          req_wdata,
  input  logic [DATA_W/8-1:0]        req_be,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic                       rsp_err,
  input  logic [NUM_REGS*DATA_W-1:0] hw_set,
  output logic [NUM_REGS*DATA_W-1:0] reg_q
);

  localparam int NUM_BYTES = DATA_W / 8;

  // Reject parameter sets the bank cannot implement.
  if (DATA_W % 8 != 0) begin : g_bad_data_w
    $error("reg_bank_hs: DATA_W must be a multiple of 8");
  end
  if (NUM_REGS < 1 || NUM_REGS > (1 << ADDR_W)) begin : g_bad_num_regs
    $error("reg_bank_hs: NUM_REGS must be in 1..2**ADDR_W");
  end

  // Response slot state: IDLE = slot empty, RESP = response presented.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;

  logic                accept;
  logic                addr_mapped;
  logic                addr_ro;
  logic [DATA_W-1:0]   rd_data;
  logic [DATA_W-1:0]   be_mask;

  assign rsp_valid   = (state_q == ST_RESP);
  assign req_ready   = !rsp_valid || rsp_ready;
  assign accept      = req_valid && req_ready;
  assign addr_mapped = ({1'b0, req_addr} < (ADDR_W+1)'(NUM_REGS));
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;

  // Expand byte enables into a per-bit write mask.
  always_comb begin
    be_mask = '0;
    for (int k = 0; k < NUM_BYTES; k++) begin
      be_mask[k*8 +: 8] = {8{req_be[k]}};
    end
  end

  // Select the addressed register and its read-only flag (zero when unmapped).
  always_comb begin
    rd_data = '0;
    addr_ro = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (req_addr == ADDR_W'(i)) begin
        rd_data = regs_q[i];
        addr_ro = RO_MASK[i];
      end
    end
  end

  // Register next state: bus write or W1C clear, then hardware set (set wins).
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (accept && req_wr && (req_addr == ADDR_W'(i)) && !RO_MASK[i]) begin
        if (W1C_MASK[i]) begin
          regs_d[i] = regs_q[i] & ~(req_wdata & be_mask);
        end else begin
          regs_d[i] = (regs_q[i] & ~be_mask) | (req_wdata & be_mask);
        end
      end
      regs_d[i] = regs_d[i] | (hw_set[i*DATA_W +: DATA_W] & {DATA_W{W1C_MASK[i]}});
    end
  end

  // Response FSM next state and response fields; fields only change on accept.
  always_comb begin
    state_d     = state_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = accept ? ST_RESP : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (accept) begin
      rsp_rdata_d = (req_wr || !addr_mapped) ? '0 : rd_data;
      rsp_err_d   = !addr_mapped || (req_wr && addr_ro);
    end
  end

  // State, response and register flops.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Flatten register contents onto the output bus.
  always_comb begin
    reg_q = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      reg_q[i*DATA_W +: DATA_W] = regs_q[i];
    end
  end

endmodule

// File: tb/tb_reg_bank_hs.sv
// Bench for reg_bank_hs: directed steps on a 16-bit, 4-register bank (reg 2 W1C,
// reg 3 RO), then a stalled request/response stream on a 32-bit, 6-register bank
// (reg 4 W1C, reg 5 RO, addresses 6..7 unmapped) checked against a small model.
module tb_reg_bank_hs;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn;

  // ---------------- instance A signals ----------------
  logic        a_req_valid, a_req_ready, a_req_wr;
  logic [1:0]  a_req_addr;
  logic [15:0] a_req_wdata;
  logic [1:0]  a_req_be;
  logic        a_rsp_valid, a_rsp_ready;
  logic [15:0] a_rsp_rdata;
  logic        a_rsp_err;
  logic [63:0] a_hw_set, a_reg_q;

  // ---------------- instance B signals ----------------
  logic         b_req_valid, b_req_ready, b_req_wr;
  logic [2:0]   b_req_addr;
  logic [31:0]  b_req_wdata;
  logic [3:0]   b_req_be;
  logic         b_rsp_valid, b_rsp_ready;
  logic [31:0]  b_rsp_rdata;
  logic         b_rsp_err;
  logic [191:0] b_hw_set, b_reg_q;

  reg_bank_hs #(
    .DATA_W(16), .ADDR_W(2), .NUM_REGS(4),
    .RO_MASK(4'b1000), .W1C_MASK(4'b0100)
  ) u_dut_a (
    .clk(clk), .rstn(rstn),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_wr(a_req_wr),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_be(a_req_be),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
    .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
    .hw_set(a_hw_set), .reg_q(a_reg_q)
  );

  reg_bank_hs #(
    .DATA_W(32), .ADDR_W(3), .NUM_REGS(6),
    .RO_MASK(6'b100000), .W1C_MASK(6'b010000)
  ) u_dut_b (
    .clk(clk), .rstn(rstn),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_wr(b_req_wr),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
    .hw_set(b_hw_set), .reg_q(b_reg_q)
  );

  // ---------------- scoreboard state ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [32:0] exp_q[$];          // {err, rdata} expected from instance B, in order
  logic [31:0] m_regs [6];        // reference contents of instance B

  logic [1:0]  rd_addr [5];
  logic [15:0] rd_exp  [5];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic a_edge();
    @(posedge clk);
    #1;
  endtask

  // One full request/response on instance A with rsp_ready held high.
  task automatic a_access(input logic wr, input logic [1:0] addr, input logic [15:0] wdata,
                          input logic [1:0] be, input logic [63:0] hw, input string tag,
                          input logic [15:0] exp_rdata, input logic exp_err);
    a_req_valid = 1'b1;
    a_req_wr    = wr;
    a_req_addr  = addr;
    a_req_wdata = wdata;
    a_req_be    = be;
    a_rsp_ready = 1'b1;
    a_hw_set    = hw;
    #1;
    chk({tag, "_req_ready"}, 64'(a_req_ready), 64'd1);
    a_edge();
    a_req_valid = 1'b0;
    a_hw_set    = '0;
    chk({tag, "_rsp_valid"}, 64'(a_rsp_valid), 64'd1);
    chk({tag, "_rdata"}, 64'(a_rsp_rdata), 64'(exp_rdata));
    chk({tag, "_err"}, 64'(a_rsp_err), 64'(exp_err));
    a_edge();
    chk({tag, "_idle"}, 64'(a_rsp_valid), 64'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] mask;
    logic [2:0]  ba;

    rstn        = 1'b0;
    a_req_valid = 1'b0; a_req_wr = 1'b0; a_req_addr = '0; a_req_wdata = '0;
    a_req_be    = '0;   a_rsp_ready = 1'b1; a_hw_set = '0;
    b_req_valid = 1'b0; b_req_wr = 1'b0; b_req_addr = '0; b_req_wdata = '0;
    b_req_be    = '0;   b_rsp_ready = 1'b1; b_hw_set = '0;
    for (int i = 0; i < 6; i++) m_regs[i] = '0;

    // Reset values
    #12;
    chk("rst_rsp_valid", 64'(a_rsp_valid), 64'd0);
    chk("rst_rsp_rdata", 64'(a_rsp_rdata), 64'd0);
    chk("rst_rsp_err",   64'(a_rsp_err),   64'd0);
    chk("rst_reg_q",     a_reg_q,          64'd0);
    rstn = 1'b1;
    a_edge();

    // Async reset while a response is stalled
    a_req_valid = 1'b1; a_req_wr = 1'b1; a_req_addr = 2'd0;
    a_req_wdata = 16'h1234; a_req_be = 2'b11; a_rsp_ready = 1'b0;
    a_edge();
    a_req_valid = 1'b0;
    chk("t1_rsp_valid", 64'(a_rsp_valid), 64'd1);
    chk("t1_reg0",      64'(a_reg_q[15:0]), 64'h1234);
    chk("t1_req_ready_stall", 64'(a_req_ready), 64'd0);
    a_edge();
    chk("t1_rsp_held", 64'(a_rsp_valid), 64'd1);
    #2 rstn = 1'b0;
    #1;
    chk("t1_async_rsp_valid", 64'(a_rsp_valid), 64'd0);
    chk("t1_async_reg_q",     a_reg_q,          64'd0);
    #1 rstn = 1'b1;
    #1;
    chk("t1_req_ready_after", 64'(a_req_ready), 64'd1);
    a_rsp_ready = 1'b1;
    a_edge();

    // Byte-lane writes and reads
    a_access(1'b1, 2'd1, 16'hABCD, 2'b01, '0, "t2_wr_lo", 16'h0000, 1'b0);
    chk("t2_reg1_lo", 64'(a_reg_q[31:16]), 64'h00CD);
    a_access(1'b0, 2'd1, 16'h0000, 2'b00, '0, "t2_rd1", 16'h00CD, 1'b0);
    a_access(1'b1, 2'd1, 16'h5500, 2'b10, '0, "t2_wr_hi", 16'h0000, 1'b0);
    chk("t2_reg1_hi", 64'(a_reg_q[31:16]), 64'h55CD);
    a_access(1'b1, 2'd1, 16'hFFFF, 2'b00, '0, "t2_wr_nobe", 16'h0000, 1'b0);
    chk("t2_reg1_nobe", 64'(a_reg_q[31:16]), 64'h55CD);
    a_access(1'b1, 2'd0, 16'hA5A5, 2'b11, '0, "t2_wr0", 16'h0000, 1'b0);
    chk("t2_reg0", 64'(a_reg_q[15:0]), 64'hA5A5);

    // Back-to-back reads, then a stalled response
    rd_addr[0] = 2'd0; rd_exp[0] = 16'hA5A5;
    rd_addr[1] = 2'd1; rd_exp[1] = 16'h55CD;
    rd_addr[2] = 2'd2; rd_exp[2] = 16'h0000;
    rd_addr[3] = 2'd3; rd_exp[3] = 16'h0000;
    rd_addr[4] = 2'd1; rd_exp[4] = 16'h55CD;
    a_rsp_ready = 1'b1;
    a_req_valid = 1'b1;
    a_req_wr    = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a_req_addr = rd_addr[i];
      #1;
      chk($sformatf("t3_ready_%0d", i), 64'(a_req_ready), 64'd1);
      a_edge();
      chk($sformatf("t3_valid_%0d", i), 64'(a_rsp_valid), 64'd1);
      chk($sformatf("t3_rdata_%0d", i), 64'(a_rsp_rdata), 64'(rd_exp[i]));
      chk($sformatf("t3_err_%0d", i),   64'(a_rsp_err),   64'd0);
    end
    a_rsp_ready = 1'b0;
    a_req_addr  = 2'd0;
    for (int j = 0; j < 3; j++) begin
      #1;
      chk($sformatf("t3_stall_ready_%0d", j), 64'(a_req_ready), 64'd0);
      a_edge();
      chk($sformatf("t3_stall_valid_%0d", j), 64'(a_rsp_valid), 64'd1);
      chk($sformatf("t3_stall_rdata_%0d", j), 64'(a_rsp_rdata), 64'h55CD);
    end
    a_rsp_ready = 1'b1;
    a_edge();
    chk("t3_resume_valid", 64'(a_rsp_valid), 64'd1);
    chk("t3_resume_rdata", 64'(a_rsp_rdata), 64'hA5A5);
    a_req_valid = 1'b0;
    a_edge();
    chk("t3_drained", 64'(a_rsp_valid), 64'd0);

    // W1C register 2, hw_set ignored on register 0
    a_access(1'b0, 2'd2, 16'h0000, 2'b00, (64'd1 << 35) | 64'h00FF, "t4_set", 16'h0000, 1'b0);
    chk("t4_reg2_set",   64'(a_reg_q[47:32]), 64'h0008);
    chk("t4_reg0_noset", 64'(a_reg_q[15:0]),  64'hA5A5);
    a_access(1'b0, 2'd2, 16'h0000, 2'b00, '0, "t4_rd2", 16'h0008, 1'b0);
    chk("t4_reg2_rd_nse", 64'(a_reg_q[47:32]), 64'h0008);
    a_access(1'b1, 2'd2, 16'hFFFF, 2'b10, '0, "t4_clr_hi", 16'h0000, 1'b0);
    chk("t4_reg2_lane", 64'(a_reg_q[47:32]), 64'h0008);
    a_access(1'b1, 2'd2, 16'h0008, 2'b11, '0, "t4_clr", 16'h0000, 1'b0);
    chk("t4_reg2_clr", 64'(a_reg_q[47:32]), 64'h0000);
    a_access(1'b0, 2'd0, 16'h0000, 2'b00, 64'd1 << 35, "t4_reset", 16'hA5A5, 1'b0);
    chk("t4_reg2_set2", 64'(a_reg_q[47:32]), 64'h0008);
    a_access(1'b1, 2'd2, 16'h0008, 2'b11, 64'd1 << 35, "t4_setwins", 16'h0000, 1'b0);
    chk("t4_reg2_setwins", 64'(a_reg_q[47:32]), 64'h0008);

    // Read-only register 3
    a_access(1'b1, 2'd3, 16'hFFFF, 2'b11, '0, "t5_wr_ro", 16'h0000, 1'b1);
    chk("t5_reg3", 64'(a_reg_q[63:48]), 64'h0000);
    a_access(1'b0, 2'd3, 16'h0000, 2'b00, '0, "t5_rd_ro", 16'h0000, 1'b0);

    // Instance B: stalled stream against the reference model
    for (int cyc = 0; cyc < 800; cyc++) begin
      b_req_valid = ($urandom_range(0, 3) != 0);
      b_req_wr    = 1'($urandom_range(0, 1));
      b_req_addr  = 3'($urandom_range(0, 7));
      b_req_wdata = $urandom;
      b_req_be    = 4'($urandom_range(0, 15));
      b_rsp_ready = ($urandom_range(0, 3) != 0);
      b_hw_set    = ($urandom_range(0, 7) == 0) ? {6{$urandom}} : '0;
      @(negedge clk);
      chk("t6_valid", 64'(b_rsp_valid), 64'(exp_q.size() != 0));
      if (b_rsp_valid && b_rsp_ready && exp_q.size() != 0) begin
        chk("t6_rsp", 64'({b_rsp_err, b_rsp_rdata}), 64'(exp_q.pop_front()));
      end
      if (b_req_valid && b_req_ready) begin
        ba = b_req_addr;
        for (int k = 0; k < 4; k++) mask[k*8 +: 8] = {8{b_req_be[k]}};
        if (ba >= 3'd6) begin
          exp_q.push_back({1'b1, 32'h0});
        end else if (!b_req_wr) begin
          exp_q.push_back({1'b0, m_regs[ba]});
        end else if (ba == 3'd5) begin
          exp_q.push_back({1'b1, 32'h0});
        end else begin
          exp_q.push_back({1'b0, 32'h0});
          if (ba == 3'd4) m_regs[4] = m_regs[4] & ~(b_req_wdata & mask);
          else            m_regs[ba] = (m_regs[ba] & ~mask) | (b_req_wdata & mask);
        end
      end
      m_regs[4] = m_regs[4] | b_hw_set[4*32 +: 32];
      @(posedge clk);
      #1;
      for (int r = 0; r < 6; r++) begin
        chk($sformatf("t6_reg%0d", r), 64'(b_reg_q[r*32 +: 32]), 64'(m_regs[r]));
      end
    end
    b_req_valid = 1'b0;
    b_rsp_ready = 1'b1;
    b_hw_set    = '0;
    @(negedge clk);
    chk("t6_drain_valid", 64'(b_rsp_valid), 64'(exp_q.size() != 0));
    if (b_rsp_valid && exp_q.size() != 0) begin
      chk("t6_drain_rsp", 64'({b_rsp_err, b_rsp_rdata}), 64'(exp_q.pop_front()));
    end
    @(posedge clk);
    #1;
    chk("t6_final_idle", 64'(b_rsp_valid), 64'd0);

    // ---------------- final report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
